tmds_word_aligner: RTL



---
 rtl/tmds_word_aligner_pkg.sv | 26 ++
 rtl/tmds_word_aligner_token_run.sv | 39 +++
 rtl/tmds_word_aligner.sv | 130 +++++++++++++
 3 files changed

// File: rtl/tmds_word_aligner_pkg.sv
// Shared TMDS receive definitions: control tokens, aligner FSM states and token test.
package tmds_word_aligner_pkg;

  localparam int unsigned SYM_W      = 10;
  localparam int unsigned SLIP_W     = 4;
  localparam int unsigned NUM_PHASES = 10;

  // The four DVI control-period characters, bit 0 first on the wire.
  localparam logic [SYM_W-1:0] CTRL_TOKEN_0 = 10'h354;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_1 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_2 = 10'h154;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_3 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  function automatic logic is_ctrl_token(input logic [SYM_W-1:0] word);
    return (word == CTRL_TOKEN_0) || (word == CTRL_TOKEN_1) ||
           (word == CTRL_TOKEN_2) || (word == CTRL_TOKEN_3);
  endfunction

endpackage

// File: rtl/tmds_word_aligner_token_run.sv
// Control-token detector with a saturating run counter; run_done_c fires once per run.
module tmds_token_run
  import tmds_word_aligner_pkg::*;
#(
  parameter int unsigned TOKEN_RUN = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [SYM_W-1:0] word_i,
  input  logic             clear_i,
  output logic             is_token_c,
  output logic             run_done_c
);

  localparam int unsigned RUN_W = $clog2(TOKEN_RUN) + 1;

  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;

  // run_done is left ungated by clear_i so callers can gate clear on it without a loop.
  always_comb begin
    is_token_c = is_ctrl_token(word_i);
    run_done_c = is_token_c && (run_cnt_q == RUN_W'(TOKEN_RUN - 1));
    run_cnt_d  = run_cnt_q;
    if (clear_i || !is_token_c) begin
      run_cnt_d = '0;
    end else if (run_cnt_q != RUN_W'(TOKEN_RUN)) begin
      run_cnt_d = run_cnt_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

endmodule

// File: rtl/tmds_word_aligner.sv
// Per-channel TMDS word aligner: slips the deserializer until control-token runs
// appear, then holds lock while runs keep arriving within LOCK_TIMEOUT.
module tmds_word_aligner
  import tmds_word_aligner_pkg::*;
#(
  parameter int unsigned TOKEN_RUN     = 8,
  parameter int unsigned SEARCH_CYCLES = 4096,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT  = 8192
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [SYM_W-1:0]  word_i,
  output logic              bitslip_o,
  output logic [SLIP_W-1:0] slip_count_o,
  output logic              aligned_o,
  output logic [SYM_W-1:0]  symbol_o,
  output logic              ctrl_token_o
);

  localparam int unsigned WIN_W = $clog2(SEARCH_CYCLES) + 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT) + 1;

  state_e            state_q, state_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [SLIP_W-1:0] slip_count_q, slip_count_d;
  logic              bitslip_q, bitslip_d;
  logic              aligned_q, aligned_d;
  logic [SYM_W-1:0]  symbol_q, symbol_d;
  logic              ctrl_token_q, ctrl_token_d;

  logic is_token_c;
  logic run_done_c;
  logic run_clear_c;

  tmds_token_run #(
    .TOKEN_RUN (TOKEN_RUN)
  ) u_token_run (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .word_i     (word_i),
    .clear_i    (run_clear_c),
    .is_token_c (is_token_c),
    .run_done_c (run_done_c)
  );

  // Next-state and counters; flags are registered from the next state.
  always_comb begin
    state_d      = state_q;
    win_cnt_d    = '0;
    set_cnt_d    = '0;
    to_cnt_d     = '0;
    slip_count_d = slip_count_q;
    run_clear_c  = 1'b0;

    unique case (state_q)
      ST_SEARCH: begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        if (run_done_c) begin
          state_d = ST_LOCKED;
        end else if (win_cnt_q == WIN_W'(SEARCH_CYCLES - 1)) begin
          state_d      = ST_SLIP;
          slip_count_d = (slip_count_q == SLIP_W'(NUM_PHASES - 1)) ?
                         '0 : slip_count_q + SLIP_W'(1);
        end
      end
      ST_SLIP: begin
        run_clear_c = 1'b1;
        state_d     = ST_SETTLE;
      end
      ST_SETTLE: begin
        run_clear_c = 1'b1;
        set_cnt_d   = set_cnt_q + SET_W'(1);
        if (set_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_SEARCH;
        end
      end
      ST_LOCKED: begin
        if (run_done_c) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          state_d     = ST_SEARCH;
          run_clear_c = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    bitslip_d    = (state_d == ST_SLIP);
    aligned_d    = (state_d == ST_LOCKED);
    symbol_d     = word_i;
    ctrl_token_d = is_token_c;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_SEARCH;
      win_cnt_q    <= '0;
      set_cnt_q    <= '0;
      to_cnt_q     <= '0;
      slip_count_q <= '0;
      bitslip_q    <= 1'b0;
      aligned_q    <= 1'b0;
      symbol_q     <= '0;
      ctrl_token_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      set_cnt_q    <= set_cnt_d;
      to_cnt_q     <= to_cnt_d;
      slip_count_q <= slip_count_d;
      bitslip_q    <= bitslip_d;
      aligned_q    <= aligned_d;
      symbol_q     <= symbol_d;
      ctrl_token_q <= ctrl_token_d;
    end
  end

  assign bitslip_o    = bitslip_q;
  assign slip_count_o = slip_count_q;
  assign aligned_o    = aligned_q;
  assign symbol_o     = symbol_q;
  assign ctrl_token_o = ctrl_token_q;

endmodule
